dispensador_rolhas: RTL
=======================

Name: dispensador_rolhas

Overview:
- Cork (rolha) supply station at the capping stage of the bottling line. It is the consumer side of the bottle flow; the dozen counter is the producer-side tally.
- Holds a cork stock count and serves one cork per capping request by pulsing the cork actuator for a fixed time. It then decrements the stock and acknowledges the request.
- Accepts operator refill batches and raises an empty alarm that the line controller uses to halt the conveyor.

Parameters:
- ESTOQUE_INICIAL, 7'd20: stock loaded at reset.
- ESTOQUE_MAX, 7'd99: saturation ceiling; stock never exceeds it (matches 2-digit display).
- LOTE_REPOSICAO, 7'd15: corks added per refill event.
- TEMPO_ATUADOR, 25'd2500000: actuator-on time in clk cycles (50 ms at 50 MHz). Must be ≥1.
- LIMIAR_BAIXO, 7'd5: low-stock threshold (optional feature only).

Ports:
- clk, input, 1: 50 MHz clock.
- reset, input, 1: asynchronous, active-low reset.
- solicitar, input, 1: capping-station request, level, already synchronous to clk.
- repor, input, 1: raw operator refill key, asynchronous.
- atuador_rolha, output, 1: cork actuator drive, high during dispense.
- rolha_concedida, output, 1: one-cycle pulse when a cork is delivered.
- erro_sem_rolha, output, 1: one-cycle pulse when a request hits empty stock.
- ocupado, output, 1: high in any state other than OCIOSO.
- estoque_valor, output, 7: current stock, 0..ESTOQUE_MAX.
- alarme_vazio, output, 1: registered, high while estoque_valor == 0.

Behaviour:
- Reset (reset low, async) forces the following; everything applies on the first clk after release:
  - estoque_valor = ESTOQUE_INICIAL.
  - atuador_rolha = 0, rolha_concedida = 0, erro_sem_rolha = 0, ocupado = 0.
  - alarme_vazio = (ESTOQUE_INICIAL == 0).
  - FSM = OCIOSO; timer = 0; synchroniser and edge registers = 0.
- Request edge: pedido = solicitar & ~solicitar_prev, where solicitar_prev is registered each cycle.
- FSM states and transitions:
  - OCIOSO:
    - pedido with stock > 0 -> DISPENSANDO; timer loads TEMPO_ATUADOR-1; atuador_rolha = 1 from the next cycle.
    - pedido with stock == 0 -> erro_sem_rolha pulses 1 cycle; go to AGUARDA_LIBERA.
  - DISPENSANDO:
    - atuador_rolha held high exactly TEMPO_ATUADOR cycles; timer decrements.
    - At timer == 0: atuador_rolha = 0, stock decrements by 1, rolha_concedida pulses on the same edge; go to AGUARDA_LIBERA.
    - solicitar dropping mid-dispense does not abort; the cork is still delivered.
  - AGUARDA_LIBERA:
    - Wait for solicitar == 0, then go to OCIOSO.
    - Exactly one cork per request edge; holding solicitar high never re-triggers.
- Latency: request edge to rolha_concedida = TEMPO_ATUADOR + 1 cycles.
- Refill path:
  - repor passes through a 2-FF synchroniser, then rising-edge detection; no debounce (the front panel debounces).
  - Each edge adds LOTE_REPOSICAO, saturating at ESTOQUE_MAX; arithmetic done at 8 bits to avoid wrap.
  - Refill is accepted in any FSM state.
- Simultaneous decrement and refill in the same cycle: new stock = min(stock - 1 + LOTE_REPOSICAO, ESTOQUE_MAX). Neither event is lost.
- Stock never underflows; a decrement only occurs from DISPENSANDO, which is entered only with stock > 0.
- alarme_vazio is registered from the next stock value, so it changes on the same edge as estoque_valor.
- Reset mid-dispense: actuator drops immediately (async) and no rolha_concedida is issued.

Optional Feature:
- Macro ROLHA_ALARME_BAIXO_EN.
- Defined:
  - Adds output port alarme_baixo (1 bit, reset value 0 before the first update).
  - alarme_baixo is registered, high while 0 < estoque_valor <= LIMIAR_BAIXO, and tracks stock on the same edge as alarme_vazio.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (TEMPO_ATUADOR=4, ESTOQUE_INICIAL=2, LOTE_REPOSICAO=15, ESTOQUE_MAX=20 for sim):
- Release reset, assert solicitar for 10 cycles:
  - atuador_rolha high exactly 4 cycles starting 1 cycle after the edge.
  - rolha_concedida pulses once at edge+5.
  - estoque_valor 2->1; no second cork while solicitar is held.
- Two request cycles from stock 2 -> stock 0 and alarme_vazio = 1. A third request -> erro_sem_rolha single pulse, atuador_rolha stays 0, stock stays 0.
- From stock 0, pulse repor (3 cycles high) -> stock 15 about 3 cycles later and alarme_vazio clears. A second repor -> stock saturates at 20, not 30.
- Stock 1 with a dispense in progress, repor edge timed to land on the decrement cycle -> stock = 15. rolha_concedida still pulses.
- Drop reset mid-DISPENSANDO (timer at 2):
  - atuador_rolha falls asynchronously; no rolha_concedida.
  - Stock = 2 and FSM in OCIOSO after release; a new request is served normally.
- With ROLHA_ALARME_BAIXO_EN and LIMIAR_BAIXO=5, refill from 2 to 17 and dispense down:
  - alarme_baixo low above 5, high from stock 5 through 1.
  - alarme_baixo low at 0, where alarme_vazio is high.

Source files
------------

// File: rtl/dispensador_rolhas.sv
// Cork supply station: serves one cork per request edge, tracks stock, takes refills.
// Optional low-stock alarm output enabled by defining ROLHA_ALARME_BAIXO_EN.
module dispensador_rolhas #(
  parameter logic [6:0]  ESTOQUE_INICIAL = 7'd20,
  parameter logic [6:0]  ESTOQUE_MAX     = 7'd99,
  parameter logic [6:0]  LOTE_REPOSICAO  = 7'd15,
  parameter logic [24:0] TEMPO_ATUADOR   = 25'd2500000
`ifdef ROLHA_ALARME_BAIXO_EN
  ,
  parameter logic [6:0]  LIMIAR_BAIXO    = 7'd5
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       solicitar,
  input  logic       repor,
  output logic       atuador_rolha,
  output logic       rolha_concedida,
  output logic       erro_sem_rolha,
  output logic       ocupado,
  output logic [6:0] estoque_valor,
  output logic       alarme_vazio
`ifdef ROLHA_ALARME_BAIXO_EN
  ,
  output logic       alarme_baixo
`endif
);

  localparam logic [1:0] OCIOSO         = 2'd0;
  localparam logic [1:0] DISPENSANDO    = 2'd1;
  localparam logic [1:0] AGUARDA_LIBERA = 2'd2;

  logic [1:0]  estado;
  logic [24:0] timer;
  logic        sol_prev;
  logic        rep_s1;
  logic        rep_s2;
  logic        rep_prev;

  logic        pedido;
  logic        rep_edge;
  logic        dec;
  logic [7:0]  soma;
  logic [6:0]  estoque_nxt;

  assign pedido   = solicitar & ~sol_prev;
  assign rep_edge = rep_s2 & ~rep_prev;
  assign dec      = (estado == DISPENSANDO) && (timer == 25'd0);
  assign ocupado  = (estado != OCIOSO);

  // 8-bit sum so a refill near the ceiling cannot wrap before saturating
  always_comb begin
    soma = {1'b0, estoque_valor} - {7'd0, dec};
    if (rep_edge) begin
      soma = soma + {1'b0, LOTE_REPOSICAO};
    end
    estoque_nxt = soma[6:0];
    if (soma > {1'b0, ESTOQUE_MAX}) begin
      estoque_nxt = ESTOQUE_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sol_prev      <= 1'b0;
      rep_s1        <= 1'b0;
      rep_s2        <= 1'b0;
      rep_prev      <= 1'b0;
      estoque_valor <= ESTOQUE_INICIAL;
      alarme_vazio  <= (ESTOQUE_INICIAL == 7'd0);
    end else begin
      sol_prev      <= solicitar;
      rep_s1        <= repor;
      rep_s2        <= rep_s1;
      rep_prev      <= rep_s2;
      estoque_valor <= estoque_nxt;
      alarme_vazio  <= (estoque_nxt == 7'd0);
    end
  end

`ifdef ROLHA_ALARME_BAIXO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarme_baixo <= 1'b0;
    end else begin
      alarme_baixo <= (estoque_nxt != 7'd0)
                   && (estoque_nxt <= LIMIAR_BAIXO);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado          <= OCIOSO;
      timer           <= 25'd0;
      atuador_rolha   <= 1'b0;
      rolha_concedida <= 1'b0;
      erro_sem_rolha  <= 1'b0;
    end else begin
      rolha_concedida <= 1'b0;
      erro_sem_rolha  <= 1'b0;
      unique case (estado)
        OCIOSO: begin
          if (pedido) begin
            if (estoque_valor != 7'd0) begin
              estado        <= DISPENSANDO;
              timer         <= TEMPO_ATUADOR - 25'd1;
              atuador_rolha <= 1'b1;
            end else begin
              erro_sem_rolha <= 1'b1;
              estado         <= AGUARDA_LIBERA;
            end
          end
        end
        DISPENSANDO: begin
          if (timer == 25'd0) begin
            atuador_rolha   <= 1'b0;
            rolha_concedida <= 1'b1;
            estado          <= AGUARDA_LIBERA;
          end else begin
            timer <= timer - 25'd1;
          end
        end
        AGUARDA_LIBERA: begin
          if (!solicitar) begin
            estado <= OCIOSO;
          end
        end
        default: begin
          estado        <= OCIOSO;
          atuador_rolha <= 1'b0;
        end
      endcase
    end
  end

endmodule
